dz_count_ctrl: RTL and testbench

Sequencer for the 8x8 red/green dot-matrix countdown display. It generates the row-scan timing (row select plus row index for the glyph lookup) and runs a second-based countdown from `START_NUM` to 0 under start/pause/reload control. It supplies the `num` digit and a blink/blank flag to the downstream glyph/column-drive block. It sits between the debounced key inputs and the dot-matrix glyph renderer.

---
 rtl/dz_pkg.sv | 23 ++
 rtl/dz_tick_div.sv | 41 ++++
 rtl/dz_count_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dz_count_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dz_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dz_pkg
//  Purpose  : Shared types and constants for the dot-matrix countdown
//             sequencer: FSM state encoding and datapath widths.
//  Revision : 1.0  initial release
// ============================================================================
package dz_pkg;

    // Sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } dz_state_t;

    localparam int DZ_ROWS  = 8;   // rows of the matrix
    localparam int DZ_NUM_W = 3;   // digit width
    localparam int DZ_ROW_W = 3;   // row index width

endpackage : dz_pkg
`default_nettype wire

// File: rtl/dz_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : dz_tick_div
//  Purpose  : Modulo-N counter with enable, synchronous clear and a
//             terminal-count pulse.
//  Ports    : clk, rst  - clock, synchronous active-high reset
//             en        - advance the count this cycle
//             clr       - force the count to 0 (wins over en)
//             cnt       - current count, 0..N-1
//             tc        - high when the count wraps on this edge
//  Revision : 1.0  initial release
// ============================================================================
module dz_tick_div #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] c_LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
    assign tc  = en && !clr && (r_cnt == c_LAST);

endmodule : dz_tick_div
`default_nettype wire

// File: rtl/dz_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dz_count_ctrl
//  Purpose  : Row-scan timing and second-based countdown sequencer for the
//             8x8 dot-matrix countdown display.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             start/pause/reload - one-cycle debounced key pulses
//             num             - current digit for the glyph block
//             row_idx, row    - active row index / active-low row select
//             blank           - blink blanking while counting is finished
//             busy, done      - RUN / DONE status
//  Revision : 1.0  initial release
// ============================================================================
module dz_count_ctrl
    import dz_pkg::*;
#(
    parameter int SCAN_DIV  = 125,
    parameter int SEC_DIV   = 1000,
    parameter int START_NUM = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic                reload,
    output logic [DZ_NUM_W-1:0] num,
    output logic [DZ_ROW_W-1:0] row_idx,
    output logic [DZ_ROWS-1:0]  row,
    output logic                blank,
    output logic                busy,
    output logic                done
);

    localparam int c_SCAN_W = $clog2(SCAN_DIV);
    localparam int c_SEC_W  = $clog2(SEC_DIV);

    localparam logic [DZ_NUM_W-1:0] c_START    = DZ_NUM_W'(START_NUM);
    localparam logic [DZ_NUM_W-1:0] c_ONE      = DZ_NUM_W'(1);
    localparam logic [c_SEC_W-1:0]  c_SEC_LAST = c_SEC_W'(SEC_DIV - 1);
    localparam logic [c_SEC_W-1:0]  c_SEC_HALF = c_SEC_W'(SEC_DIV / 2);
    localparam logic [DZ_ROWS-1:0]  c_ROW_RST  = {{(DZ_ROWS-1){1'b1}}, 1'b0};

    dz_state_t             r_state, w_state_nxt;
    logic [DZ_NUM_W-1:0]   r_num, w_num_nxt;
    logic                  r_restart, w_restart;
    logic                  r_busy, r_done, r_blank;
    logic [DZ_ROW_W-1:0]   r_row_idx;
    logic [DZ_ROWS-1:0]    r_row;

    logic [c_SCAN_W-1:0]   w_scan_cnt_unused;
    logic                  w_scan_tc;
    logic [c_SEC_W-1:0]    w_sec_cnt, w_sec_nxt;
    logic                  w_sec_tc, w_sec_en, w_sec_clr, w_tick;

    // ---------------------------------------------------------------- scan
    dz_tick_div #(.N(SCAN_DIV), .W(c_SCAN_W)) u_scan_div (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (1'b0),
        .cnt (w_scan_cnt_unused),
        .tc  (w_scan_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_idx <= '0;
            r_row     <= c_ROW_RST;
        end else if (w_scan_tc) begin
            r_row_idx <= r_row_idx + 1'b1;
            r_row     <= {r_row[DZ_ROWS-2:0], r_row[DZ_ROWS-1]};
        end
    end

    // -------------------------------------------------------------- second
    // The counter is also held for the cycle following a (re)start
    // (r_restart), so the first decrement lands SEC_DIV+1 edges after the
    // start pulse and every later one SEC_DIV edges apart.
    assign w_sec_en  = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign w_sec_clr = (r_state == ST_IDLE) || reload || w_restart || r_restart;

    dz_tick_div #(.N(SEC_DIV), .W(c_SEC_W)) u_sec_div (
        .clk (clk),
        .rst (rst),
        .en  (w_sec_en),
        .clr (w_sec_clr),
        .cnt (w_sec_cnt),
        .tc  (w_sec_tc)
    );

    assign w_tick = (r_state == ST_RUN) && w_sec_tc;

    // Next value of the second counter, so blank can be registered yet
    // still track the counter without a cycle of lag.
    always_comb begin
        w_sec_nxt = w_sec_cnt;
        if (w_sec_clr) begin
            w_sec_nxt = '0;
        end else if (w_sec_en) begin
            w_sec_nxt = (w_sec_cnt == c_SEC_LAST) ? '0 : w_sec_cnt + 1'b1;
        end
    end

    // ----------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt = r_state;
        w_num_nxt   = r_num;
        w_restart   = 1'b0;
        if (reload) begin
            w_state_nxt = ST_IDLE;
            w_num_nxt   = c_START;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_restart   = 1'b1;
                        w_state_nxt = (c_START == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tick && (r_num != '0)) begin
                        w_num_nxt = r_num - 1'b1;
                    end
                    // Reaching zero outranks a simultaneous pause.
                    if (w_tick && (r_num == c_ONE)) begin
                        w_state_nxt = ST_DONE;
                    end else if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start || pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        w_restart   = 1'b1;
                        w_num_nxt   = c_START;
                        w_state_nxt = (c_START == '0) ? ST_DONE : ST_RUN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_num     <= c_START;
            r_restart <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_blank   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_num     <= w_num_nxt;
            r_restart <= w_restart;
            r_busy    <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
            r_blank   <= (w_state_nxt == ST_DONE) && (w_sec_nxt >= c_SEC_HALF);
        end
    end

    assign num     = r_num;
    assign row_idx = r_row_idx;
    assign row     = r_row;
    assign blank   = r_blank;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule : dz_count_ctrl
`default_nettype wire

// File: tb/tb_dz_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dz_count_ctrl
//  Purpose  : Self-checking bench for dz_count_ctrl (SCAN_DIV=4, SEC_DIV=10,
//             START_NUM=5, plus a START_NUM=0 instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dz_count_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int SEC_DIV  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, pause = 1'b0, reload = 1'b0;
    logic [2:0] num, row_idx;
    logic [7:0] row;
    logic       blank, busy, done;

    logic       start0 = 1'b0, pause0 = 1'b0, reload0 = 1'b0;
    logic [2:0] num0, row_idx0;
    logic [7:0] row0;
    logic       blank0, busy0, done0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } exp_t;
    exp_t sb[$];

    dz_count_ctrl #(.SCAN_DIV(SCAN_DIV), .SEC_DIV(SEC_DIV), .START_NUM(5)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .reload(reload),
        .num(num), .row_idx(row_idx), .row(row), .blank(blank),
        .busy(busy), .done(done)
    );

    dz_count_ctrl #(.SCAN_DIV(SCAN_DIV), .SEC_DIV(SEC_DIV), .START_NUM(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pause(pause0), .reload(reload0),
        .num(num0), .row_idx(row_idx0), .row(row0), .blank(blank0),
        .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_scan();
        int         r;
        logic [2:0] ei;
        logic [7:0] er;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        r = cyc;
        n_cmp++;
        if (num !== 3'd5 || row !== 8'hFE || row_idx !== 3'd0 ||
            busy !== 1'b0 || done !== 1'b0 || blank !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: num=%0d row=%h idx=%0d busy=%b done=%b blank=%b want 5 fe 0 0 0 0",
                     num, row, row_idx, busy, done, blank);
        end
        n_cmp++;
        if (num0 !== 3'd0 || done0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_zero_inst: num=%0d done=%b want 0 0", num0, done0);
        end
        for (int k = 1; k <= 32; k++) begin
            step(1);
            ei = 3'((k / SCAN_DIV) % 8);
            er = ~(8'h01 << ei);
            n_cmp++;
            if (row_idx !== ei || row !== er) begin
                n_bad++;
                $display("FAIL scan_k%0d: idx=%0d row=%h want idx=%0d row=%h", k, row_idx, row, ei, er);
            end
        end
        if (cyc != r + 32) $display("note: scan loop cycle drift %0d", cyc - r);
    endtask

    // ------------------------------------------------------------------
    task automatic test_countdown();
        int         e, guard;
        exp_t       x;
        logic [2:0] prev;
        logic       eb;
        start = 1'b1; step(1); start = 1'b0;
        e = cyc;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_start: busy=%b done=%b want 1 0", busy, done);
        end
        for (int k = 1; k <= 5; k++) sb.push_back('{e + 1 + SEC_DIV * k, 3'(5 - k)});
        prev = num; guard = 0;
        while (sb.size() != 0 && guard < 80) begin
            step(1); guard++;
            if (num !== prev) begin
                x = sb.pop_front();
                n_cmp++;
                if (num !== x.val || cyc != x.cyc) begin
                    n_bad++;
                    $display("FAIL countdown_num: got %0d at E+%0d want %0d at E+%0d", num, cyc - e, x.val, x.cyc - e);
                end
                prev = num;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL countdown_timeout: %0d digits pending want 0", sb.size());
            sb.delete();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_at_zero: done=%b busy=%b want 1 0", done, busy);
        end
        // After the final tick the second counter restarts from 0.
        for (int j = 1; j <= 20; j++) begin
            step(1);
            eb = ((j % SEC_DIV) >= SEC_DIV / 2);
            n_cmp++;
            if (blank !== eb) begin
                n_bad++;
                $display("FAIL blink_j%0d: blank=%b want %b", j, blank, eb);
            end
        end
        // Back-to-back restart from DONE.
        start = 1'b1; step(1); start = 1'b0;
        e = cyc;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || num !== 3'd5 || blank !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_from_done: busy=%b done=%b num=%0d blank=%b want 1 0 5 0", busy, done, num, blank);
        end
        sb.push_back('{e + 1 + SEC_DIV, 3'd4});
        prev = num; guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            step(1); guard++;
            if (num !== prev) begin
                x = sb.pop_front();
                n_cmp++;
                if (num !== x.val || cyc != x.cyc) begin
                    n_bad++;
                    $display("FAIL restart_first_dec: got %0d at E+%0d want %0d at E+%0d", num, cyc - e, x.val, x.cyc - e);
                end
                prev = num;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL restart_timeout: %0d pending want 0", sb.size());
            sb.delete();
        end
        reload = 1'b1; step(1); reload = 1'b0;
        n_cmp++;
        if (num !== 3'd5 || busy !== 1'b0 || done !== 1'b0 || blank !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_idle: num=%0d busy=%b done=%b blank=%b want 5 0 0 0", num, busy, done, blank);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pause();
        int         e, guard;
        exp_t       x;
        logic [2:0] prev;
        start = 1'b1; step(1); start = 1'b0;
        e = cyc;
        sb.push_back('{e + 11, 3'd4});
        prev = num; guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            step(1); guard++;
            if (num !== prev) begin
                x = sb.pop_front();
                n_cmp++;
                if (num !== x.val || cyc != x.cyc) begin
                    n_bad++;
                    $display("FAIL pause_first_dec: got %0d at E+%0d want %0d at E+%0d", num, cyc - e, x.val, x.cyc - e);
                end
                prev = num;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL pause_first_timeout: %0d pending want 0", sb.size());
            sb.delete();
        end
        while (cyc < e + 13) step(1);
        pause = 1'b1; step(1); pause = 1'b0;   // edge E+14
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL paused_status: busy=%b done=%b want 0 0", busy, done);
        end
        while (cyc < e + 33) begin
            step(1);
            n_cmp++;
            if (num !== 3'd4) begin
                n_bad++;
                $display("FAIL paused_hold at E+%0d: num=%0d want 4", cyc - e, num);
            end
        end
        pause = 1'b1; step(1); pause = 1'b0;   // edge E+34
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL resume_busy: busy=%b want 1", busy);
        end
        sb.push_back('{e + 41, 3'd3});
        prev = num; guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            step(1); guard++;
            if (num !== prev) begin
                x = sb.pop_front();
                n_cmp++;
                if (num !== x.val || cyc != x.cyc) begin
                    n_bad++;
                    $display("FAIL resume_dec: got %0d at E+%0d want %0d at E+%0d", num, cyc - e, x.val, x.cyc - e);
                end
                prev = num;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL resume_timeout: %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        n_cmp++;
        if (num !== 3'd3 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_pre: num=%0d busy=%b want 3 1", num, busy);
        end
        rst = 1'b1; start = 1'b1;
        step(1);
        n_cmp++;
        if (num !== 3'd5 || row !== 8'hFE || row_idx !== 3'd0 ||
            busy !== 1'b0 || done !== 1'b0 || blank !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: num=%0d row=%h idx=%0d busy=%b done=%b blank=%b want 5 fe 0 0 0 0",
                     num, row, row_idx, busy, done, blank);
        end
        step(1);
        rst = 1'b0; start = 1'b0;
        step(3);
        n_cmp++;
        if (busy !== 1'b0 || num !== 3'd5) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy=%b num=%0d want 0 5", busy, num);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority();
        int e;
        start = 1'b1; pause = 1'b1; step(1); start = 1'b0; pause = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_start_pause: busy=%b want 1", busy);
        end
        step(4);
        reload = 1'b1; start = 1'b1; step(1); reload = 1'b0; start = 1'b0;
        n_cmp++;
        if (num !== 3'd5 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_beats_start: num=%0d busy=%b done=%b want 5 0 0", num, busy, done);
        end
        step(15);
        n_cmp++;
        if (num !== 3'd5 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_stays: num=%0d busy=%b want 5 0", num, busy);
        end
        start = 1'b1; step(1); start = 1'b0;
        e = cyc;
        while (cyc < e + 50) step(1);
        n_cmp++;
        if (num !== 3'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL tick_pause_pre: num=%0d busy=%b want 1 1", num, busy);
        end
        pause = 1'b1; step(1); pause = 1'b0;   // edge E+51 carries the last tick
        n_cmp++;
        if (num !== 3'd0 || done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL tick_pause_done: num=%0d done=%b busy=%b want 0 1 0", num, done, busy);
        end
        step(12);
        n_cmp++;
        if (done !== 1'b1 || num !== 3'd0) begin
            n_bad++;
            $display("FAIL done_holds: done=%b num=%0d want 1 0", done, num);
        end
        reload = 1'b1; step(1); reload = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_start_zero();
        logic saw_busy, saw_num;
        n_cmp++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_idle: done=%b busy=%b want 0 0", done0, busy0);
        end
        start0 = 1'b1; step(1); start0 = 1'b0;
        n_cmp++;
        if (done0 !== 1'b1 || num0 !== 3'd0 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_start: done=%b num=%0d busy=%b want 1 0 0", done0, num0, busy0);
        end
        saw_busy = 1'b0; saw_num = 1'b0;
        for (int j = 0; j < 25; j++) begin
            step(1);
            if (busy0 !== 1'b0) saw_busy = 1'b1;
            if (num0 !== 3'd0) saw_num = 1'b1;
        end
        n_cmp++;
        if (saw_busy !== 1'b0 || saw_num !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_hold: busy_seen=%b num_moved=%b want 0 0", saw_busy, saw_num);
        end
        start0 = 1'b1; step(1); start0 = 1'b0;
        n_cmp++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || num0 !== 3'd0) begin
            n_bad++;
            $display("FAIL zero_restart: done=%b busy=%b num=%0d want 1 0 0", done0, busy0, num0);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset_scan();
        test_countdown();
        test_pause();
        test_mid_reset();
        test_priority();
        test_start_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit reached");
    end

endmodule : tb_dz_count_ctrl
`default_nettype wire
